// File: rtl/register_load_sched.sv
// register_load_sched
//
// Purpose: generates the two non-overlapping phase clocks (phi1/phi2) of a
// CPU bus cycle. It also generates one-clk load strobes for the address-bus
// low/high registers and the predecode register, and counts completed cycles.
// A cycle is PHI1 (PHASE_LEN clks), GAP1 (GAP clks), PHI2 (PHASE_LEN clks
// plus any ready-stretch clks) and GAP2 (GAP clks). A GAP of 0 removes the
// gap states.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous active-high reset
//   enable       - run the cycle generator; a started cycle always completes
//   ab_lo_req    - request abl_load, sampled on the edge entering PHI1
//   ab_hi_req    - request abh_load, sampled on the edge entering PHI1
//   pd_req       - request pd_load, sampled on the edge entering the final PHI2 clk
//   rdy          - ready; low on a read cycle stretches phi2
//   rw           - 1 = read cycle, 0 = write cycle
//   phi1, phi2   - phase clocks, never high together
//   abl_load     - one-clk strobe in the first PHI1 clk
//   abh_load     - one-clk strobe in the first PHI1 clk
//   pd_load      - one-clk strobe in the final PHI2 clk
//   cycle_count  - completed CPU cycles, wraps at 16 bits
//
// Every output comes straight from a flop that is loaded from the next-state
// logic, so no input reaches an output combinationally.
module register_load_sched #(
    parameter int PHASE_LEN = 2,
    parameter int GAP       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ab_lo_req,
    input  logic        ab_hi_req,
    input  logic        pd_req,
    input  logic        rdy,
    input  logic        rw,
    output logic        phi1,
    output logic        phi2,
    output logic        abl_load,
    output logic        abh_load,
    output logic        pd_load,
    output logic [15:0] cycle_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PHI1 = 3'd1;
    localparam logic [2:0] GAP1 = 3'd2;
    localparam logic [2:0] PHI2 = 3'd3;
    localparam logic [2:0] GAP2 = 3'd4;

    localparam logic [3:0] PL = 4'(PHASE_LEN);
    localparam logic [3:0] GL = 4'(GAP);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] count_q, count_d;
    logic        phi1_q, phi2_q, abl_q, abh_q, pd_q;
    logic        stall;
    logic        endOfCycle;
    logic        enterPhi2;
    logic        enterPhi1;
    logic [3:0]  nextIdx;

    assign stall = ~rdy & rw;

    // Next-state logic. cnt_q holds the 1-based index of the current clk
    // within its state (0 in IDLE). In PHI2, index 0 marks a stretch clk.
    // A stretch clk is inserted whenever the next clk would be the final
    // PHI2 clk while a read is not ready. Because of this, the final PHI2
    // clk is known on the edge that enters it, so pd_load can be a
    // registered output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        endOfCycle = 1'b0;
        enterPhi2  = 1'b0;
        nextIdx    = 4'd0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PHI1;
                    cnt_d   = 4'd1;
                end
            end
            PHI1: begin
                if (cnt_q == PL) begin
                    if (GL == 4'd0) begin
                        enterPhi2 = 1'b1;
                    end else begin
                        state_d = GAP1;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP1: begin
                if (cnt_q == GL) begin
                    enterPhi2 = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PHI2: begin
                if (cnt_q == PL) begin
                    if (GL == 4'd0) begin
                        endOfCycle = 1'b1;
                    end else begin
                        state_d = GAP2;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    nextIdx = (cnt_q == 4'd0) ? PL : cnt_q + 4'd1;
                    cnt_d   = (nextIdx == PL && stall) ? 4'd0 : nextIdx;
                end
            end
            GAP2: begin
                if (cnt_q == GL) begin
                    endOfCycle = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (enterPhi2) begin
            state_d = PHI2;
            cnt_d   = (PL == 4'd1 && stall) ? 4'd0 : 4'd1;
        end

        if (endOfCycle) begin
            state_d = enable ? PHI1 : IDLE;
            cnt_d   = enable ? 4'd1 : 4'd0;
        end
    end

    assign enterPhi1 = (state_d == PHI1) && (state_q != PHI1);
    assign count_d   = count_q + {15'd0, endOfCycle};

    // State, counter and output flops. Reset takes priority over everything,
    // including a stretch in progress, and clears every strobe and sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            count_q <= 16'd0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            abl_q   <= 1'b0;
            abh_q   <= 1'b0;
            pd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            phi1_q  <= (state_d == PHI1);
            phi2_q  <= (state_d == PHI2);
            abl_q   <= enterPhi1 & ab_lo_req;
            abh_q   <= enterPhi1 & ab_hi_req;
            pd_q    <= (state_d == PHI2) && (cnt_d == PL) && pd_req;
        end
    end

    assign phi1        = phi1_q;
    assign phi2        = phi2_q;
    assign abl_load    = abl_q;
    assign abh_load    = abh_q;
    assign pd_load     = pd_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_register_load_sched.sv
// tb_register_load_sched
//
// Testbench for register_load_sched. It runs the default configuration
// (PHASE_LEN=2, GAP=1) and a GAP=0 instance. Expected values come from a
// constant vector table, hand-written corner sequences, and a cycle-position
// reference model driven by random stimulus.
module tb_register_load_sched;

    localparam int PL = 2;
    localparam int G  = 1;
    localparam int L  = 2 * PL + 2 * G;
    localparam int F  = 2 * PL + G - 1;

    logic        clk = 1'b0;
    logic        reset, enable, abLoReq, abHiReq, pdReq, rdy, rw;
    logic        phi1, phi2, ablLoad, abhLoad, pdLoad;
    logic [15:0] cycleCount;

    logic        reset0, enable0;
    logic        phi1Z, phi2Z, ablZ, abhZ, pdZ;
    logic [15:0] countZ;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: position within the nominal cycle timeline.
    int          mActive, mPos, mStretch;
    logic [15:0] mCyc;
    logic        mAbl, mAbh, mPd;

    typedef struct {
        logic        rst, en, lo, hi, pd, rdy, rw;
        logic        ePhi1, ePhi2, eAbl, eAbh, ePd;
        logic [15:0] eCnt;
    } vec_t;

    vec_t vecs[17];

    // Clock generation for both instances.
    always #5 clk = ~clk;

    register_load_sched #(.PHASE_LEN(PL), .GAP(G)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ab_lo_req(abLoReq), .ab_hi_req(abHiReq), .pd_req(pdReq),
        .rdy(rdy), .rw(rw),
        .phi1(phi1), .phi2(phi2), .abl_load(ablLoad), .abh_load(abhLoad),
        .pd_load(pdLoad), .cycle_count(cycleCount)
    );

    register_load_sched #(.PHASE_LEN(2), .GAP(0)) dut0 (
        .clk(clk), .reset(reset0), .enable(enable0),
        .ab_lo_req(1'b0), .ab_hi_req(1'b0), .pd_req(1'b0),
        .rdy(1'b1), .rw(1'b1),
        .phi1(phi1Z), .phi2(phi2Z), .abl_load(ablZ), .abh_load(abhZ),
        .pd_load(pdZ), .cycle_count(countZ)
    );

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic startCycle();
        mActive  = 1;
        mPos     = 0;
        mStretch = 0;
        mAbl     = abLoReq;
        mAbh     = abHiReq;
    endtask

    // One clk edge of the model, using the inputs the DUT sampled on that edge.
    task automatic modelStep();
        int cand;
        mAbl = 1'b0;
        mAbh = 1'b0;
        mPd  = 1'b0;
        if (reset) begin
            mActive = 0; mPos = 0; mStretch = 0; mCyc = 16'd0;
        end else if (mActive == 0) begin
            if (enable) startCycle();
        end else if (mStretch == 0 && mPos == L - 1) begin
            mCyc = mCyc + 16'd1;
            if (enable) startCycle();
            else mActive = 0;
        end else begin
            cand = (mStretch != 0) ? F : mPos + 1;
            if (cand == F && rw && !rdy) begin
                mStretch = 1;
            end else begin
                mStretch = 0;
                mPos     = cand;
                mPd      = (cand == F) && pdReq;
            end
        end
    endtask

    function automatic logic [31:0] modelBundle();
        logic p1, p2;
        p1 = (mActive != 0) && (mStretch == 0) && (mPos < PL);
        p2 = (mActive != 0) && ((mStretch != 0) || (mPos >= PL + G && mPos <= F));
        return {11'd0, p1, p2, mAbl, mAbh, mPd, mCyc};
    endfunction

    function automatic logic [31:0] dutBundle();
        return {11'd0, phi1, phi2, ablLoad, abhLoad, pdLoad, cycleCount};
    endfunction

    // Advance one clk: the edge, the model update, then the opposite edge where
    // outputs are sampled and the next inputs are driven.
    task automatic stepClock();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset   = v.rst; enable = v.en; abLoReq = v.lo; abHiReq = v.hi;
        pdReq   = v.pd;  rdy    = v.rdy; rw     = v.rw;
        stepClock();
    endtask

    task automatic setVec(input int i, input logic [6:0] ins, input logic [4:0] outs,
                          input logic [15:0] cnt);
        vecs[i] = '{ins[6], ins[5], ins[4], ins[3], ins[2], ins[1], ins[0],
                    outs[4], outs[3], outs[2], outs[1], outs[0], cnt};
    endtask

    initial begin
        int phi2Highs, pdPulses, pdEdge, firstCountEdge;

        reset = 1'b1; enable = 1'b0; abLoReq = 1'b0; abHiReq = 1'b0;
        pdReq = 1'b0; rdy = 1'b1; rw = 1'b1;
        reset0 = 1'b1; enable0 = 1'b0;
        mActive = 0; mPos = 0; mStretch = 0; mCyc = 16'd0;
        mAbl = 1'b0; mAbh = 1'b0; mPd = 1'b0;

        // Inputs {rst,en,lo,hi,pd,rdy,rw}; outputs {phi1,phi2,abl,abh,pd}.
        setVec(0,  7'b1000011, 5'b00000, 16'd0);
        setVec(1,  7'b0110111, 5'b10100, 16'd0);
        setVec(2,  7'b0110111, 5'b10000, 16'd0);
        setVec(3,  7'b0110111, 5'b00000, 16'd0);
        setVec(4,  7'b0110111, 5'b01000, 16'd0);
        setVec(5,  7'b0110111, 5'b01001, 16'd0);
        setVec(6,  7'b0110111, 5'b00000, 16'd0);
        setVec(7,  7'b0101000, 5'b10010, 16'd1);
        setVec(8,  7'b0100000, 5'b10000, 16'd1);
        setVec(9,  7'b0100000, 5'b00000, 16'd1);
        setVec(10, 7'b0100000, 5'b01000, 16'd1);
        setVec(11, 7'b0100100, 5'b01001, 16'd1);
        setVec(12, 7'b0000000, 5'b00000, 16'd1);
        setVec(13, 7'b0000000, 5'b00000, 16'd2);
        setVec(14, 7'b0000000, 5'b00000, 16'd2);
        setVec(15, 7'b0111011, 5'b10110, 16'd2);
        setVec(16, 7'b1000011, 5'b00000, 16'd0);

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), dutBundle(),
                        {11'd0, vecs[i].ePhi1, vecs[i].ePhi2, vecs[i].eAbl,
                         vecs[i].eAbh, vecs[i].ePd, vecs[i].eCnt});
        end

        // Read stretch: rdy low on edges 5..7 of the cycle.
        reset = 1'b1; stepClock();
        reset = 1'b0; enable = 1'b1; rw = 1'b1; pdReq = 1'b1;
        abLoReq = 1'b0; abHiReq = 1'b0;
        phi2Highs = 0; pdPulses = 0; pdEdge = 0; firstCountEdge = 0;
        for (int e = 1; e <= 12; e++) begin
            rdy = !(e >= 5 && e <= 7);
            stepClock();
            checkOutput($sformatf("stretchModel%0d", e), dutBundle(), modelBundle());
            if (e <= 9 && phi2) phi2Highs++;
            if (e <= 9 && pdLoad) begin pdPulses++; pdEdge = e; end
            if (firstCountEdge == 0 && cycleCount == 16'd1) firstCountEdge = e;
        end
        checkOutput("stretchPhi2Clks", phi2Highs, 32'd5);
        checkOutput("stretchPdPulses", pdPulses, 32'd1);
        checkOutput("stretchPdFinalClk", pdEdge, 32'd8);
        checkOutput("stretchCycleLen", firstCountEdge - 1, 32'd9);

        // Mid-cycle reset on the edge entering the second PHI2 clk.
        reset = 1'b1; rdy = 1'b1; stepClock();
        reset = 1'b0; enable = 1'b1; pdReq = 1'b1;
        for (int e = 1; e <= 10; e++) stepClock();
        checkOutput("preResetCount", {16'd0, cycleCount}, 32'd1);
        reset = 1'b1; stepClock();
        checkOutput("midResetOutputs", dutBundle(), 32'd0);
        reset = 1'b0; enable = 1'b0; stepClock();
        checkOutput("postResetOutputs", dutBundle(), 32'd0);

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 49) == 0);
            enable  = ($urandom_range(0, 9) != 0);
            abLoReq = 1'($urandom_range(0, 1));
            abHiReq = 1'($urandom_range(0, 1));
            pdReq   = 1'($urandom_range(0, 1));
            rdy     = ($urandom_range(0, 9) < 7);
            rw      = 1'($urandom_range(0, 1));
            stepClock();
            checkOutput($sformatf("rand%0d", i), dutBundle(), modelBundle());
            checkOutput($sformatf("randPhiExcl%0d", i), {31'd0, phi1 & phi2}, 32'd0);
        end

        // Counter wrap: preload near the top while idle, then run two cycles.
        reset = 1'b1; enable = 1'b0; rdy = 1'b1; rw = 1'b1; stepClock();
        reset = 1'b0; stepClock();
        force dut.count_q = 16'hFFFE;
        stepClock();
        release dut.count_q;
        mCyc = 16'hFFFE;
        enable = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            stepClock();
            checkOutput($sformatf("wrap%0d", e), dutBundle(), modelBundle());
        end
        checkOutput("wrapToZero", {16'd0, cycleCount}, 32'd0);

        // GAP=0 instance: phi1 and phi2 alternate every 2 clks.
        reset = 1'b1; enable = 1'b0;
        reset0 = 1'b1; stepClock();
        reset0 = 1'b0; enable0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            stepClock();
            checkOutput($sformatf("gap0Phase%0d", k), {30'd0, phi1Z, phi2Z},
                        ((k % 4) < 2) ? 32'd2 : 32'd1);
        end
        checkOutput("gap0Count", {16'd0, countZ}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/register_load_sched.md
REGISTER_LOAD_SCHED -- requirements
Module: register_load_sched

Interface
REQ-001 Parameter PHASE_LEN, default 2, is the number of clk cycles each of phi1/phi2 is high; legal range 1..15.
REQ-002 Parameter GAP, default 1, is the number of non-overlap dead clk cycles after each phase; legal range 0..3, where 0 means no gap state.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: run the CPU cycle generator.
REQ-006 Port ab_lo_req, input, 1 bit: request an address-bus-low register load in the next CPU cycle.
REQ-007 Port ab_hi_req, input, 1 bit: request an address-bus-high register load in the next CPU cycle.
REQ-008 Port pd_req, input, 1 bit: request a predecode register load at the end of the current cycle.
REQ-009 Port rdy, input, 1 bit: ready; when low on a read cycle, it stretches phi2.
REQ-010 Port rw, input, 1 bit: 1 for a read cycle, 0 for a write cycle.
REQ-011 Port phi1, output, 1 bit: phase-1 clock.
REQ-012 Port phi2, output, 1 bit: phase-2 clock.
REQ-013 Port abl_load, output, 1 bit: one-clk load strobe for the address-bus-low register.
REQ-014 Port abh_load, output, 1 bit: one-clk load strobe for the address-bus-high register.
REQ-015 Port pd_load, output, 1 bit: one-clk load strobe for the predecode register.
REQ-016 Port cycle_count, output, 16 bits: number of completed CPU cycles.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-018 The FSM SHALL have the states IDLE, PHI1, GAP1, PHI2, GAP2, tracked by a phase counter for dwell time.
REQ-019 IDLE SHALL go to PHI1 on the next clk when enable=1, and SHALL otherwise stay in IDLE.
REQ-020 PHI1 SHALL dwell PHASE_LEN clks, then go to GAP1, or to PHI2 when GAP=0.
REQ-021 GAP1 SHALL dwell GAP clks, then go to PHI2.
REQ-022 PHI2 SHALL dwell at least PHASE_LEN clks, then go to GAP2, or to the end of cycle when GAP=0.
REQ-023 GAP2 SHALL dwell GAP clks, then go to the end of cycle.
REQ-024 At end of cycle, the FSM SHALL go to PHI1 if enable=1 and to IDLE otherwise.
REQ-025 enable falling mid-cycle SHALL NOT truncate the cycle; the cycle always completes.
REQ-026 phi1 SHALL be 1 only in PHI1, and phi2 SHALL be 1 only in PHI2; phi1 and phi2 SHALL never both be 1.
REQ-027 With rdy=0 and rw=1 sampled in the final PHI2 clk, the FSM SHALL remain in PHI2 (phi2 held high), re-evaluating every clk.
REQ-028 rdy=0 on a write cycle (rw=0) SHALL be ignored.
REQ-029 ab_lo_req and ab_hi_req SHALL be sampled on the clk edge that enters PHI1.
REQ-030 abl_load and abh_load SHALL each be high for exactly the first clk of PHI1 when their sampled request is 1; the two are independent and may assert together.
REQ-031 pd_req SHALL be sampled on the edge entering the final PHI2 clk, i.e. the clk after which PHI2 exits.
REQ-032 pd_load SHALL be high for exactly that final PHI2 clk when the sample is 1, and SHALL NOT assert during stretch clks.
REQ-033 Each strobe SHALL be at most one pulse per CPU cycle, with no back-to-back high clks.
REQ-034 cycle_count SHALL increment by 1 at each end of cycle and SHALL wrap from 16'hFFFF to 0.
REQ-035 Nominal cycle length SHALL be 2*PHASE_LEN + 2*GAP clks, plus any stretch clks.

Reset
REQ-036 reset=1 at a clk edge SHALL force IDLE, phase counter 0, all strobes 0, phi1=phi2=0, cycle_count=0, and sampled requests cleared.
REQ-037 reset SHALL take priority over every other input, including mid-cycle and mid-stretch; no strobe SHALL be emitted on the reset edge or the following clk.
REQ-038 The first PHI1 after reset release SHALL begin one clk after enable=1 is sampled in IDLE.

Verification (PHASE_LEN=2, GAP=1)
REQ-039 Free-run: reset, then enable=1 with rdy=1 -> phi1 high 2 clks, low 1, phi2 high 2, low 1, repeating every 6 clks; cycle_count=3 after 18 clks.
REQ-040 Strobes: ab_lo_req=1, ab_hi_req=0, pd_req=1 -> abl_load pulses on the first phi1 clk, abh_load stays 0, and pd_load pulses on the second phi2 clk; each pulse is 1 clk wide.
REQ-041 Stretch: rw=1 with rdy=0 for 3 clks at the end of PHI2 -> phi2 high 5 clks, pd_load only on the final clk, cycle length 9.
REQ-042 Write ignores rdy: rw=0 with rdy=0 -> cycle length stays 6 and phi2 stays 2 clks.
REQ-043 Mid-cycle reset: reset asserted on the second PHI2 clk -> next clk all outputs 0 and cycle_count=0, with no pd_load pulse.
REQ-044 Wrap and GAP=0: force 65535 cycles -> cycle_count returns to 0; with GAP=0, phi1 and phi2 alternate every 2 clks and are never both high.
